// File: rtl/regfile_2r1w_clr.sv
// Purpose : parametrised register file, one synchronous write port, two
//           registered read ports and a sequenced bulk-clear engine.
// Latency : reads 1 cycle; bulk clear takes DEPTH cycles plus a 1-cycle done pulse.
// Backpressure : writes are dropped (not queued) while Busy; Clr_req is
//           ignored unless the engine is idle.
//
// Ports:
//   Clk, Reset            rising-edge clock, asynchronous active-high reset
//   Wr_en/Wr_addr/Wr_data write strobe, address, data (out-of-range ignored)
//   Rd_addr_a/Rd_addr_b   read addresses; Rd_out_a/Rd_out_b registered data
//                         (0 for out-of-range addresses)
//   Clr_req               bulk-clear request, sampled on Clk
//   Busy                  high while the clear sequence runs
//   Clr_done              one-cycle pulse when the clear completes
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-edge read of an address being written returns Wr_data
//   undefined : a same-edge read returns the pre-write register value

module regfile_2r1w_clr #(
    parameter int             WID     = 4,
    parameter int             DEPTH   = 4,
    parameter int             AW      = 2,
    parameter logic [WID-1:0] RST_VAL = '0
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Wr_en,
    input  logic [AW-1:0]  Wr_addr,
    input  logic [WID-1:0] Wr_data,
    input  logic [AW-1:0]  Rd_addr_a,
    input  logic [AW-1:0]  Rd_addr_b,
    output logic [WID-1:0] Rd_out_a,
    output logic [WID-1:0] Rd_out_b,
    input  logic           Clr_req,
    output logic           Busy,
    output logic           Clr_done
);

    // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [WID-1:0] mem_q [DEPTH];
    logic [WID-1:0] mem_d [DEPTH];
    logic [WID-1:0] rd_a_q, rd_a_d;
    logic [WID-1:0] rd_b_q, rd_b_d;

    logic busy;
    logic wr_fire;
    logic rd_a_in_range;
    logic rd_b_in_range;

    // Busy/Clr_done are pure decodes of the state register, so they are
    // glitch-free and drop the instant Reset forces the state to idle.
    assign busy     = (state_q == ST_CLEAR);
    assign Busy     = busy;
    assign Clr_done = (state_q == ST_DONE);
    assign Rd_out_a = rd_a_q;
    assign Rd_out_b = rd_b_q;

    assign wr_fire       = Wr_en && !busy && ({1'b0, Wr_addr} < DEPTH_W);
    assign rd_a_in_range = ({1'b0, Rd_addr_a} < DEPTH_W);
    assign rd_b_in_range = ({1'b0, Rd_addr_b} < DEPTH_W);

    // Clear sequencer: IDLE -> CLEAR (DEPTH cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register array next state. A write and a clear never hit the same
    // cycle because writes are gated off while the clear engine is busy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_fire && (Wr_addr == i[AW-1:0])) begin
                mem_d[i] = Wr_data;
            end
            if (busy && (cnt_q == i[AW-1:0])) begin
                mem_d[i] = RST_VAL;
            end
        end
    end

    // Read muxes sample the pre-write contents; the optional bypass
    // overrides them with the data being written on the same edge.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_a_in_range && (Rd_addr_a == i[AW-1:0])) begin
                rd_a_d = mem_q[i];
            end
            if (rd_b_in_range && (Rd_addr_b == i[AW-1:0])) begin
                rd_b_d = mem_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (Wr_addr == Rd_addr_a)) begin
            rd_a_d = Wr_data;
        end
        if (wr_fire && (Wr_addr == Rd_addr_b)) begin
            rd_b_d = Wr_data;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Purpose : randomized + directed bench for regfile_2r1w_clr, DEPTH=4 and DEPTH=3 instances
// Latency : compares outputs each falling edge against a cycle-count reference model
// Backpressure : n/a (bench drives every input every cycle)

module tb_regfile_2r1w_clr;

    logic       Clk;
    logic       Reset;
    logic       Wr_en;
    logic [1:0] Wr_addr;
    logic [3:0] Wr_data;
    logic [1:0] Rd_addr_a;
    logic [1:0] Rd_addr_b;
    logic       Clr_req;

    logic [3:0] rd_a4, rd_b4, rd_a3, rd_b3;
    logic       busy4, done4, busy3, done3;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_2r1w_clr #(.WID(4), .DEPTH(4), .AW(2), .RST_VAL(4'h0)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .Rd_addr_a(Rd_addr_a), .Rd_addr_b(Rd_addr_b), .Rd_out_a(rd_a4), .Rd_out_b(rd_b4),
        .Clr_req(Clr_req), .Busy(busy4), .Clr_done(done4)
    );

    regfile_2r1w_clr #(.WID(4), .DEPTH(3), .AW(2), .RST_VAL(4'h0)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .Rd_addr_a(Rd_addr_a), .Rd_addr_b(Rd_addr_b), .Rd_out_a(rd_a3), .Rd_out_b(rd_b3),
        .Clr_req(Clr_req), .Busy(busy3), .Clr_done(done3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model. Clear progress is tracked as "edges since the clear
    // was accepted": 0 = idle, 1..D = busy (edge k clears entry k-1),
    // D+1 = done pulse.
    int         dep [2] = '{4, 3};
    logic [3:0] mm  [2][4];
    logic [3:0] m_ra[2];
    logic [3:0] m_rb[2];
    int         cs  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mm[k][i] = 4'h0;
            m_ra[k] = 4'h0;
            m_rb[k] = 4'h0;
            cs[k]   = 0;
        end
    endtask

    task automatic model_step(input int we, input int wa, input logic [3:0] wd,
                              input int ra, input int rb, input int req);
        for (int k = 0; k < 2; k++) begin
            int  d;
            bit  bz;
            bit  wfire;
            d     = dep[k];
            bz    = (cs[k] >= 1) && (cs[k] <= d);
            wfire = (we != 0) && !bz && (wa < d);
            m_ra[k] = (ra < d) ? mm[k][ra] : 4'h0;
            m_rb[k] = (rb < d) ? mm[k][rb] : 4'h0;
`ifdef REGFILE_BYPASS_EN
            if (wfire && wa == ra) m_ra[k] = wd;
            if (wfire && wa == rb) m_rb[k] = wd;
`endif
            if (wfire) mm[k][wa] = wd;
            if (bz) mm[k][cs[k]-1] = 4'h0;
            if (cs[k] == 0)       cs[k] = (req != 0) ? 1 : 0;
            else if (cs[k] <= d)  cs[k] = cs[k] + 1;
            else                  cs[k] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/rd_a4"}, rd_a4, m_ra[0]);
        check({tag, "/rd_b4"}, rd_b4, m_rb[0]);
        check({tag, "/busy4"}, busy4, (cs[0] >= 1 && cs[0] <= 4));
        check({tag, "/done4"}, done4, (cs[0] == 5));
        check({tag, "/rd_a3"}, rd_a3, m_ra[1]);
        check({tag, "/rd_b3"}, rd_b3, m_rb[1]);
        check({tag, "/busy3"}, busy3, (cs[1] >= 1 && cs[1] <= 3));
        check({tag, "/done3"}, done3, (cs[1] == 4));
    endtask

    // Called at a falling edge: drive, take the rising edge, compare at the next falling edge.
    task automatic step(input string tag, input int we, input int wa, input logic [3:0] wd,
                        input int ra, input int rb, input int req);
        Wr_en     = (we != 0);
        Wr_addr   = 2'(wa);
        Wr_data   = wd;
        Rd_addr_a = 2'(ra);
        Rd_addr_b = 2'(rb);
        Clr_req   = (req != 0);
        @(posedge Clk);
        model_step(we, wa, wd, ra, rb, req);
        @(negedge Clk);
        compare_all(tag);
    endtask

    initial begin
        int nb, nd;
        bit hold;
        Reset = 1'b1;
        Wr_en = 1'b0; Wr_addr = '0; Wr_data = '0;
        Rd_addr_a = '0; Rd_addr_b = '0; Clr_req = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Reset contents on every address, both ports.
        for (int i = 0; i < 4; i++) step("rd_reset", 0, 0, 4'h0, i, 3 - i, 0);

        // Basic write/read.
        step("wr2", 1, 2, 4'hA, 0, 0, 0);
        step("wr1", 1, 1, 4'h5, 0, 0, 0);
        step("rd21", 0, 0, 4'h0, 2, 1, 0);
        check("rd_a_addr2", rd_a4, 4'hA);
        check("rd_b_addr1", rd_b4, 4'h5);

        // Read-during-write on the same address.
        step("wr3_old", 1, 3, 4'h2, 0, 0, 0);
        step("rdw3", 1, 3, 4'h7, 3, 0, 0);
`ifdef REGFILE_BYPASS_EN
        check("rdw_bypass", rd_a4, 4'h7);
`else
        check("rdw_old", rd_a4, 4'h2);
`endif
        step("rd3_new", 0, 0, 4'h0, 3, 3, 0);
        check("rd3_new_val", rd_a4, 4'h7);

        // Fill with F, one-cycle clear pulse, writes attempted while busy.
        for (int i = 0; i < 4; i++) step("fillF", 1, i, 4'hF, i, i, 0);
        step("clr_req", 0, 0, 4'h0, 0, 1, 1);
        nb = busy4 ? 1 : 0;
        nd = done4 ? 1 : 0;
        for (int c = 0; c < 7; c++) begin
            step("clr_run", busy4 ? 1 : 0, 0, 4'h9, c % 4, 3 - (c % 4), 0);
            if (busy4) nb++;
            if (done4) nd++;
        end
        check("clr_busy_cycles", nb, 4);
        check("clr_done_pulses", nd, 1);
        for (int i = 0; i < 4; i++) begin
            step("rd_cleared", 0, 0, 4'h0, i, i, 0);
            check("cleared_val", rd_a4, 4'h0);
        end

        // Asynchronous reset in the middle of a clear, at cnt == 1.
        for (int i = 0; i < 4; i++) step("fill_ar", 1, i, 4'(i + 3), 0, 0, 0);
        step("ar_req", 0, 0, 4'h0, 1, 2, 1);
        step("ar_cnt1", 0, 0, 4'h0, 1, 2, 0);
        check("ar_busy_before", busy4, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("ar_busy_now", busy4, 1'b0);
        check("ar_done_now", done4, 1'b0);
        check("ar_rd_a_now", rd_a4, 4'h0);
        check("ar_rd_b_now", rd_b4, 4'h0);
        model_reset();
        @(negedge Clk);
        compare_all("ar_held");
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) step("ar_rd", 0, 0, 4'h0, i, 3 - i, 0);

        // Out-of-range write on the DEPTH=3 instance.
        for (int i = 0; i < 3; i++) step("d3_fill", 1, i, 4'(i + 1), 0, 0, 0);
        step("d3_wr3", 1, 3, 4'hC, 0, 0, 0);
        step("d3_rd3", 0, 0, 4'h0, 3, 0, 0);
        check("d3_oob_read", rd_a3, 4'h0);
        check("d3_reg0", rd_b3, 4'h1);
        for (int i = 0; i < 3; i++) step("d3_rd", 0, 0, 4'h0, i, i, 0);

        // Clr_req held high: clear repeats back-to-back with one idle edge.
        for (int c = 0; c < 14; c++)
            step("clr_hold", 1, c % 4, 4'($urandom_range(0, 15)), c % 4, (c + 1) % 4, 1);

        // Random traffic.
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            step("rand", ($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, 3),
                 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 (hold || $urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
